uart_tx: RTL

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_fifo.sv | 55 +++++
 rtl/uart_tx.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg -- shared definitions for the UART transmit path.
//   uart_tx_state_t : transmitter FSM state encoding
//   uart_period()   : clk cycles per line bit (CLK_FREQ / BAUD_RATE, truncated)
// -----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_tx_state_t;

   function automatic int unsigned uart_period(input int unsigned clk_freq,
                                               input int unsigned baud_rate);
      return clk_freq / baud_rate;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo -- synchronous FIFO buffering words ahead of the serialiser.
//   clk, rst : clock, synchronous active-high reset (empties the FIFO)
//   push     : write wdata (ignored when full)
//   wdata    : word to store
//   pop      : drop the head entry (ignored when empty)
//   rdata    : head entry, valid while !empty
//   full     : DEPTH entries held
//   empty    : no entries held
// DEPTH must be a power of two >= 2; pointers carry an extra wrap bit so that
// full and empty are distinguishable when the index bits are equal.
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rdata   = mem[rd_ptr[AW-1:0]];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx -- buffered asynchronous serial transmitter (start, data LSB first,
// optional even parity, 1 or 2 stop bits).
//   clk        : clock
//   rst        : synchronous active-high reset; aborts any frame, empties FIFO
//   data       : word to send (DATA_BITS wide)
//   data_valid : producer offers data
//   data_ready : FIFO can accept (low while full or in reset)
//   tx         : registered serial line, idle high
//   busy       : frame in progress or words queued
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit after
// the data bits.
// -----------------------------------------------------------------------------
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 100000000,
   parameter int BAUD_RATE  = 9600,
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] data,
   input  logic                 data_valid,
   output logic                 data_ready,
   output logic                 tx,
   output logic                 busy
);

   localparam int unsigned PERIOD = uart_period(CLK_FREQ, BAUD_RATE);
   localparam int unsigned BW     = $clog2(PERIOD + 1);
   localparam int unsigned CW     = $clog2(DATA_BITS + 1);

   localparam logic [BW-1:0] BAUD_LAST = BW'(PERIOD - 1);
   localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
   localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

   uart_tx_state_t       state;
   logic [BW-1:0]        baud_cnt;
   logic [CW-1:0]        bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 stop_tail;
   logic                 line_bit;
   logic                 bit_end;
   logic                 push;
   logic                 pop;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [DATA_BITS-1:0] fifo_rdata;
`ifdef UART_TX_PARITY_EN
   logic                 parity;
`endif

   assign data_ready = !fifo_full && !rst;
   assign push       = data_valid && data_ready;
   assign bit_end    = (baud_cnt == BAUD_LAST);

   // Head word moves into the shifter when leaving IDLE, or at the end of the
   // last stop bit so the next start bit follows with no idle gap.
   assign pop = !fifo_empty &&
                ((state == IDLE) || (state == STOP && bit_end && bit_cnt == STOP_LAST));

   // tx lags the FSM by one register stage; stop_tail covers the final stop
   // cycle still on the line after the FSM has already returned to IDLE.
   assign busy = (state != IDLE) || !fifo_empty || stop_tail;

   uart_tx_fifo #(
      .WIDTH(DATA_BITS),
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (push),
      .wdata(data),
      .pop  (pop),
      .rdata(fifo_rdata),
      .full (fifo_full),
      .empty(fifo_empty)
   );

   always_comb begin
      line_bit = 1'b1;
      case (state)
         START:   line_bit = 1'b0;
         DATA:    line_bit = shreg[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  line_bit = parity;
`endif
         default: line_bit = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         baud_cnt  <= '0;
         bit_cnt   <= '0;
         shreg     <= '0;
         stop_tail <= 1'b0;
         tx        <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parity    <= 1'b0;
`endif
      end else begin
         tx        <= line_bit;
         stop_tail <= 1'b0;
         if (pop) begin
            shreg  <= fifo_rdata;
`ifdef UART_TX_PARITY_EN
            parity <= ^fifo_rdata;
`endif
         end
         case (state)
            IDLE: begin
               if (!fifo_empty) begin
                  state    <= START;
                  baud_cnt <= '0;
               end
            end
            START: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  bit_cnt  <= '0;
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt + BW'(1);
               end
            end
            DATA: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  shreg    <= shreg >> 1;
                  if (bit_cnt == DATA_LAST) begin
                     bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                     state   <= PARITY;
`else
                     state   <= STOP;
`endif
                  end else begin
                     bit_cnt <= bit_cnt + CW'(1);
                  end
               end else begin
                  baud_cnt <= baud_cnt + BW'(1);
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  bit_cnt  <= '0;
                  state    <= STOP;
               end else begin
                  baud_cnt <= baud_cnt + BW'(1);
               end
            end
`endif
            STOP: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  if (bit_cnt == STOP_LAST) begin
                     bit_cnt   <= '0;
                     state     <= fifo_empty ? IDLE : START;
                     stop_tail <= fifo_empty;
                  end else begin
                     bit_cnt <= bit_cnt + CW'(1);
                  end
               end else begin
                  baud_cnt <= baud_cnt + BW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
